// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory access sequencer.
//
// Takes the load/store sitting in the EX/MEM register and turns it into a
// single 64-bit-wide dmem transaction. The pipeline is frozen (mem_stall)
// while the request is outstanding. Each access then spends exactly one
// un-stalled DONE cycle, where the formatted load data is presented to MEM/WB.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   MEM_MemRead/Write    load / store in MEM (both high = store)
//   MEM_Alu_result       byte address
//   MEM_RegData2         store data, LSB-aligned
//   MEM_funct3           size/sign: B H W D BU HU WU, 111 = D
//   dmem_req/we/addr     request valid, write, doubleword-aligned address
//   dmem_wdata/wstrb     size-replicated store data, byte enables
//   dmem_ack/rdata       one-cycle completion pulse, read data valid with ack
//   mem_stall            freeze all pipeline registers
//   MemReadData          formatted load result (valid in DONE only)
//   misaligned           combinational flag for an unaligned access in IDLE
//   bus_error            no ack within the timeout window (DONE cycle only)
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [63:0] MEM_Alu_result,
  input  logic [63:0] MEM_RegData2,
  input  logic [2:0]  MEM_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output logic [63:0] MemReadData,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // The WAIT counter reads 0 in the first WAIT cycle. Timing out when it
  // reads 254 means the access gives up after 255 WAIT cycles without ack;
  // the counter would read 255 on the following edge.
  localparam logic [7:0] TMO_LAST = 8'd254;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [63:0] cap_q;
  logic        berr_q;

  // Request latched on issue so WAIT drives a stable bus whatever happens
  // on the pipeline-side inputs.
  logic        q_we, q_load;
  logic [63:0] q_addr, q_wdata;
  logic [7:0]  q_wstrb;
  logic [2:0]  q_f3, q_off;

  // Live decode of the MEM-stage instruction.
  logic        access, aligned, is_load;
  logic [1:0]  size;
  logic [2:0]  off;
  logic [63:0] line_addr, wdata_live;
  logic [7:0]  mask, wstrb_live;

  assign access    = MEM_MemRead | MEM_MemWrite;
  assign is_load   = MEM_MemRead & ~MEM_MemWrite;
  assign size      = MEM_funct3[1:0];   // 111 falls into D naturally
  assign off       = MEM_Alu_result[2:0];
  assign line_addr = {MEM_Alu_result[63:3], 3'b000};

  always_comb begin
    aligned    = 1'b1;
    mask       = 8'hFF;
    wdata_live = MEM_RegData2;
    case (size)
      2'd0: begin
        aligned    = 1'b1;
        mask       = 8'h01;
        wdata_live = {8{MEM_RegData2[7:0]}};
      end
      2'd1: begin
        aligned    = ~off[0];
        mask       = 8'h03;
        wdata_live = {4{MEM_RegData2[15:0]}};
      end
      2'd2: begin
        aligned    = (off[1:0] == 2'd0);
        mask       = 8'h0F;
        wdata_live = {2{MEM_RegData2[31:0]}};
      end
      default: begin
        aligned    = (off == 3'd0);
        mask       = 8'hFF;
        wdata_live = MEM_RegData2;
      end
    endcase
  end

  assign wstrb_live = mask << off;

  // Pick the addressed lane out of the doubleword and extend it.
  function automatic logic [63:0] fmt_load(input logic [63:0] d,
                                           input logic [2:0]  f3,
                                           input logic [2:0]  o);
    logic [63:0] lane;
    lane = d >> {o, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{56{lane[7]}},  lane[7:0]};
      3'b001:  fmt_load = {{48{lane[15]}}, lane[15:0]};
      3'b010:  fmt_load = {{32{lane[31]}}, lane[31:0]};
      3'b100:  fmt_load = {56'd0, lane[7:0]};
      3'b101:  fmt_load = {48'd0, lane[15:0]};
      3'b110:  fmt_load = {32'd0, lane[31:0]};
      default: fmt_load = lane;
    endcase
  endfunction

  // Next state and outputs.
  always_comb begin
    state_d     = state_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = 64'd0;
    dmem_wdata  = 64'd0;
    dmem_wstrb  = 8'd0;
    mem_stall   = 1'b0;
    MemReadData = 64'd0;
    misaligned  = 1'b0;
    bus_error   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            dmem_req   = 1'b1;
            mem_stall  = 1'b1;
            dmem_we    = MEM_MemWrite;
            dmem_addr  = line_addr;
            dmem_wdata = MEM_MemWrite ? wdata_live : 64'd0;
            dmem_wstrb = MEM_MemWrite ? wstrb_live : 8'd0;
            state_d    = dmem_ack ? DONE : WAIT;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      WAIT: begin
        dmem_req   = 1'b1;
        mem_stall  = 1'b1;
        dmem_we    = q_we;
        dmem_addr  = q_addr;
        dmem_wdata = q_wdata;
        dmem_wstrb = q_wstrb;
        if (dmem_ack || cnt_q == TMO_LAST) state_d = DONE;
      end
      DONE: begin
        MemReadData = cap_q;
        bus_error   = berr_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Request and stall must drop the moment reset is raised, even if the
    // pipeline inputs still show an access.
    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cap_q   <= 64'd0;
      berr_q  <= 1'b0;
      q_we    <= 1'b0;
      q_load  <= 1'b0;
      q_addr  <= 64'd0;
      q_wdata <= 64'd0;
      q_wstrb <= 8'd0;
      q_f3    <= 3'd0;
      q_off   <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (access && aligned) begin
            q_we    <= MEM_MemWrite;
            q_load  <= is_load;
            q_addr  <= line_addr;
            q_wdata <= MEM_MemWrite ? wdata_live : 64'd0;
            q_wstrb <= MEM_MemWrite ? wstrb_live : 8'd0;
            q_f3    <= MEM_funct3;
            q_off   <= off;
            cnt_q   <= 8'd0;
            berr_q  <= 1'b0;
            if (dmem_ack)
              cap_q <= is_load ? fmt_load(dmem_rdata, MEM_funct3, off) : 64'd0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            cap_q <= q_load ? fmt_load(dmem_rdata, q_f3, q_off) : 64'd0;
          end else if (cnt_q == TMO_LAST) begin
            cap_q  <= 64'd0;
            berr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: berr_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        MEM_MemRead, MEM_MemWrite;
  logic [63:0] MEM_Alu_result, MEM_RegData2;
  logic [2:0]  MEM_funct3;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        mem_stall;
  logic [63:0] MemReadData;
  logic        misaligned, bus_error;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Alu_result(MEM_Alu_result), .MEM_RegData2(MEM_RegData2),
    .MEM_funct3(MEM_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .MemReadData(MemReadData),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    MEM_MemRead = 0; MEM_MemWrite = 0; MEM_Alu_result = 0;
    MEM_RegData2 = 0; MEM_funct3 = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    n_chk++; if (MemReadData !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", MemReadData); end
    n_chk++; if (bus_error !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got be=%b mis=%b want 0 0", bus_error, misaligned); end
  endtask

  task automatic test_ld_fast();
    MEM_MemRead = 1; MEM_funct3 = 3'b011; MEM_Alu_result = 64'h1000;
    dmem_ack = 1; dmem_rdata = 64'h1122334455667788;
    #1;
    n_chk++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL ld_issue: got req=%b stall=%b want 1 1", dmem_req, mem_stall); end
    n_chk++; if (dmem_addr !== 64'h1000 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_addr: got %h we=%b want 1000 0", dmem_addr, dmem_we); end
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall: got stall=%b req=%b want 0 0", mem_stall, dmem_req); end
    n_chk++; if (MemReadData !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_data: got %h want 1122334455667788", MemReadData); end
    MEM_MemRead = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_lb_wait(input logic [2:0] f3, input logic [63:0] exp);
    int n = 0;
    bit bad = 0;
    MEM_MemRead = 1; MEM_funct3 = f3; MEM_Alu_result = 64'h1005; dmem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dmem_ack = 1; dmem_rdata = 64'h0000_8000_0000_0000; end
      #1;
      if (mem_stall) n++;
      if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000) bad = 1;
      @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0;
    end
    #1;
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL lb_stall_cycles f3=%0d: got %0d want 4", f3, n); end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL lb_req_hold f3=%0d: got unstable want stable", f3); end
    n_chk++; if (mem_stall !== 1'b0 || MemReadData !== exp) begin n_fail++; $display("FAIL lb_data f3=%0d: got %h stall=%b want %h 0", f3, MemReadData, mem_stall, exp); end
    MEM_MemRead = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_sh_store();
    MEM_MemWrite = 1; MEM_funct3 = 3'b001; MEM_Alu_result = 64'h2006;
    MEM_RegData2 = 64'hABCD; dmem_ack = 0;
    #1;
    n_chk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sh_req: got req=%b we=%b want 1 1", dmem_req, dmem_we); end
    n_chk++; if (dmem_wstrb !== 8'hC0) begin n_fail++; $display("FAIL sh_wstrb: got %h want c0", dmem_wstrb); end
    n_chk++; if (dmem_wdata !== 64'hABCDABCDABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcdabcdabcd", dmem_wdata); end
    n_chk++; if (dmem_addr !== 64'h2000) begin n_fail++; $display("FAIL sh_addr: got %h want 2000", dmem_addr); end
    @(posedge clk); #1; dmem_ack = 1; #1;
    n_chk++; if (mem_stall !== 1'b1 || dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'hABCDABCDABCDABCD || dmem_addr !== 64'h2000)
      begin n_fail++; $display("FAIL sh_wait_hold: got stall=%b strb=%h wd=%h a=%h want 1 c0 abcdabcdabcdabcd 2000", mem_stall, dmem_wstrb, dmem_wdata, dmem_addr); end
    @(posedge clk); #1; dmem_ack = 0; #1;
    n_chk++; if (mem_stall !== 1'b0 || MemReadData !== 64'd0) begin n_fail++; $display("FAIL sh_done: got stall=%b data=%h want 0 0", mem_stall, MemReadData); end
    MEM_MemWrite = 0; MEM_RegData2 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    MEM_MemRead = 1; MEM_funct3 = 3'b010; MEM_Alu_result = 64'h3002;
    dmem_rdata = 64'hDEADBEEF;
    #1;
    n_chk++; if (misaligned !== 1'b1 || dmem_req !== 1'b0 || mem_stall !== 1'b0 || MemReadData !== 64'd0)
      begin n_fail++; $display("FAIL mis_flags: got mis=%b req=%b stall=%b data=%h want 1 0 0 0", misaligned, dmem_req, mem_stall, MemReadData); end
    @(posedge clk); #1; #1;
    n_chk++; if (misaligned !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_stay_idle: got mis=%b req=%b want 1 0", misaligned, dmem_req); end
    MEM_MemRead = 0; #1;
    n_chk++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misaligned); end
    dmem_rdata = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_both_store();
    MEM_MemRead = 1; MEM_MemWrite = 1; MEM_funct3 = 3'b011;
    MEM_Alu_result = 64'h5000; MEM_RegData2 = 64'h55;
    dmem_ack = 1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_chk++; if (dmem_we !== 1'b1 || dmem_wstrb !== 8'hFF || dmem_wdata !== 64'h55)
      begin n_fail++; $display("FAIL both_store: got we=%b strb=%h wd=%h want 1 ff 55", dmem_we, dmem_wstrb, dmem_wdata); end
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (MemReadData !== 64'd0) begin n_fail++; $display("FAIL both_data: got %h want 0", MemReadData); end
    MEM_MemRead = 0; MEM_MemWrite = 0; MEM_RegData2 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    MEM_MemRead = 1; MEM_funct3 = 3'b010; MEM_Alu_result = 64'h1004;
    dmem_ack = 1; dmem_rdata = 64'h8000_0000_0000_0000;
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (MemReadData !== 64'hFFFF_FFFF_8000_0000 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL b2b_lw: got %h req=%b want ffffffff80000000 0", MemReadData, dmem_req); end
    @(posedge clk); #1;
    MEM_funct3 = 3'b101; MEM_Alu_result = 64'h1002;
    dmem_ack = 1; dmem_rdata = 64'h0000_0000_BEEF_0000; #1;
    n_chk++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000) begin n_fail++; $display("FAIL b2b_reissue: got req=%b a=%h want 1 1000", dmem_req, dmem_addr); end
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (MemReadData !== 64'h0000_0000_0000_BEEF) begin n_fail++; $display("FAIL b2b_lhu: got %h want beef", MemReadData); end
    MEM_MemRead = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1; dmem_rdata = 64'h1234; #1;
    n_chk++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack_req: got stall=%b req=%b want 0 0", mem_stall, dmem_req); end
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (MemReadData !== 64'd0) begin n_fail++; $display("FAIL idle_ack_ignored: got %h want 0", MemReadData); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n = 0;
    MEM_MemRead = 1; MEM_funct3 = 3'b011; MEM_Alu_result = 64'h4000; dmem_ack = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!mem_stall) break;
      n++;
      @(posedge clk); #1;
    end
    n_chk++; if (n !== 256) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d want 256", n); end
    n_chk++; if (bus_error !== 1'b1 || MemReadData !== 64'd0 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL tmo_done: got be=%b data=%h req=%b want 1 0 0", bus_error, MemReadData, dmem_req); end
    MEM_MemRead = 0;
    @(posedge clk); #1; #1;
    n_chk++; if (bus_error !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got be=%b stall=%b want 0 0", bus_error, mem_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    MEM_MemRead = 1; MEM_funct3 = 3'b011; MEM_Alu_result = 64'h6000; dmem_ack = 0;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    n_chk++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL rst_wait_pre: got req=%b stall=%b want 1 1", dmem_req, mem_stall); end
    reset = 1; MEM_MemRead = 0; #1;
    n_chk++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_wait_drop: got req=%b stall=%b want 0 0", dmem_req, mem_stall); end
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1; dmem_ack = 1; dmem_rdata = 64'h1234; #1;
    n_chk++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack_req: got stall=%b req=%b want 0 0", mem_stall, dmem_req); end
    @(posedge clk); #1; dmem_ack = 0; dmem_rdata = 0; #1;
    n_chk++; if (MemReadData !== 64'd0 || bus_error !== 1'b0 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL rst_late_ack_out: got data=%h be=%b req=%b want 0 0 0", MemReadData, bus_error, dmem_req); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 0;
    @(posedge clk); #1;
    test_ld_fast();
    test_lb_wait(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
    test_lb_wait(3'b100, 64'h0000_0000_0000_0080);
    test_sh_store();
    test_misaligned();
    test_both_store();
    test_back_to_back();
    test_idle_ack();
    test_timeout();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clock clk.
REQ-003 SHALL have: MEM_MemRead  in  1  load in MEM stage (from EX/MEM register).
REQ-004 SHALL have: MEM_MemWrite  in  1  store in MEM stage.
REQ-005 SHALL have: MEM_Alu_result  in  64  byte address.
REQ-006 SHALL have: MEM_RegData2  in  64  store data, LSB-aligned.
REQ-007 SHALL have: MEM_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 treated as D).
REQ-008 SHALL have: dmem_req  out  1  request valid; dmem_we  out  1  write; dmem_addr  out  64  {addr[63:3],3'b000}; dmem_wdata  out  64; dmem_wstrb  out  8  byte enables.
REQ-009 SHALL have: dmem_ack  in  1  one-cycle completion pulse; dmem_rdata  in  64  valid with ack.
REQ-010 SHALL have: mem_stall  out  1  freeze all pipeline registers; MemReadData  out  64  to MEM/WB; misaligned  out  1; bus_error  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-012 access = MEM_MemRead | MEM_MemWrite; aligned = addr offset multiple of access size (B any, H addr[0]=0, W addr[1:0]=0, D addr[2:0]=0).
REQ-013 IDLE, access & aligned: dmem_req=1 and mem_stall=1 combinationally, same cycle.
REQ-014 IDLE with ack: capture rdata, go DONE; without ack: go WAIT.
REQ-015 WAIT: dmem_req, dmem_we, dmem_addr, wdata, wstrb held stable; mem_stall=1; ack -> capture rdata, go DONE.
REQ-016 DONE: dmem_req=0, mem_stall=0, MemReadData=formatted captured data; unconditional -> IDLE next cycle.
REQ-017 Minimum access = 2 cycles (IDLE with ack, DONE); back-to-back accesses re-enter IDLE between them.
REQ-018 MemRead & MemWrite both high: treat as store; MemReadData=0 in DONE.
REQ-019 Store: wdata = size-replicated store data (B x8, H x4, W x2, D x1); wstrb = size mask shifted by addr[2:0] (B 0x01, H 0x03, W 0x0F, D 0xFF).
REQ-020 Load: select lane by addr[2:0], sign-extend for B/H/W, zero-extend for BU/HU/WU.
REQ-021 Misaligned access in IDLE: no request, misaligned=1 combinational, mem_stall=0, MemReadData=0, state stays IDLE.
REQ-022 WAIT timeout: 8-bit counter cleared on entering WAIT, +1 per WAIT cycle; at 255 without ack -> DONE with bus_error=1 for that DONE cycle, MemReadData=0.
REQ-023 Ack in IDLE with no access, or in DONE: ignored, no state change.
REQ-024 No access in IDLE: dmem_req=0, mem_stall=0, MemReadData=0, misaligned=0.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, counter 0, captured data 0, bus_error 0; dmem_req and mem_stall drop immediately.
REQ-026 reset mid-WAIT SHALL abandon the access; a subsequent late ack SHALL be ignored.

Verification
REQ-027 LD addr 0x1000, ack in IDLE, rdata 0x1122334455667788 -> stall high 1 cycle, DONE MemReadData=0x1122334455667788.
REQ-028 LB addr 0x1005, ack after 3 WAIT cycles, rdata 0x0000_8000_0000_0000 -> stall 4 cycles, MemReadData=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-029 SH addr 0x2006, data 0xABCD -> dmem_we=1, wstrb=0xC0, wdata=0xABCDABCDABCDABCD, dmem_addr=0x2000.
REQ-030 LW addr 0x3002 -> misaligned=1, dmem_req=0, mem_stall=0, MemReadData=0.
REQ-031 LD, no ack for 255 WAIT cycles -> DONE, bus_error=1, MemReadData=0, then IDLE.
REQ-032 reset asserted in WAIT, released, ack pulses later -> dmem_req=0 immediately, state IDLE, ack ignored, outputs 0.
